wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Writeback stage directly upstream of the register file: merges results from the single-cycle
//  ALU path and the variable-latency load (LSU) path into one write port (waddr/wdata/we).
//  Each source is buffered in its own small FIFO; one regfile write per cycle, LSU-priority
//  with an anti-starvation guard for the ALU path. Writes to x0 are dropped at enqueue.
// PARAMETERS
//  DEPTH      4   entries per source FIFO (power of two, >=2)
//  STARVE_MAX 3   consecutive cycles ALU head may lose before it is forced to win
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  flush      in   1   discard all ALU-FIFO entries (speculative results); LSU FIFO untouched
//  alu_valid  in   1   ALU result offered
//  alu_ready  out  1   ALU FIFO can accept (not full)
//  alu_rd     in   5   destination register
//  alu_data   in   32  result value
//  lsu_valid  in   1   load result offered
//  lsu_ready  out  1   LSU FIFO can accept (not full)
//  lsu_rd     in   5   destination register
//  lsu_data   in   32  loaded value
//  we         out  1   regfile write enable
//  waddr      out  5   regfile write address
//  wdata      out  32  regfile write data
//  busy_vec   out  32  [WB_SCOREBOARD_EN only] bit r set while a write to xr is queued
// BEHAVIOUR
//  - Reset: both FIFOs empty, starve counter 0; we=0, waddr=0, wdata=0, alu_ready=lsu_ready=1.
//  - Handshake: transfer when valid&&ready at rising edge; ready = !full, independent of valid.
//  - rd==0 transfers are accepted (handshake completes) but not enqueued.
//  - Latency: entry accepted at edge N into empty FIFO is presented (we=1) during cycle N+1;
//    regfile captures it at edge ending N+1. No same-cycle bypass from inputs to we.
//  - we/waddr/wdata are combinational from the winning FIFO head; waddr=wdata=0 when we=0.
//  - Arbitration per cycle: if both heads valid: ALU wins when starve==STARVE_MAX, else LSU wins.
//    starve increments when ALU head valid and loses; clears when ALU pops or ALU FIFO empty.
//  - Winner's head pops at the edge ending the cycle it is presented; one pop per cycle total.
//  - Simultaneous push and pop on a full FIFO: ready is still 0 (no write-through when full).
//  - Same rd queued in both FIFOs: order between sources is not guaranteed; upstream hazard
//    logic (busy_vec) must prevent it. Within one FIFO order is strict.
//  - flush: at edge, ALU FIFO cleared, starve cleared; an ALU push in the same cycle is
//    discarded; if ALU head was presented that cycle, the write still occurs (we already high).
//  - Pointers are log2(DEPTH)+1 bits; full = MSBs differ and LSBs equal; wrap is natural.
//  - Async reset mid-operation discards all queued results; we drops immediately.
// CONFIGURATION
//  WB_SCOREBOARD_EN defined: busy_vec = OR over valid entries of both FIFOs of onehot(rd),
//    combinational, bit 0 always 0; reflects contents after each edge.
//  Undefined: busy_vec port absent; no per-entry compare logic.
// STRUCTURE
//  Package wb_pkg: XLEN=32, REG_AW=5, typedef wb_entry_t {rd[4:0], data[31:0]}.
//  Sub-module wb_fifo (parameter DEPTH; push/pop/full/empty/head, flush input, entries
//    exposed for scoreboard); instantiated twice (alu, lsu). Arbiter + starve counter at top.
// TESTING
//  1 ALU push rd=5 data=0xDEAD at edge N, LSU idle -> we=1 waddr=5 wdata=0xDEAD in cycle N+1 only.
//  2 Same cycle ALU rd=1/0x11 and LSU rd=2/0x22 -> LSU write first (x2), ALU next cycle (x1).
//  3 LSU pushes every cycle, ALU one entry queued -> ALU wins after exactly STARVE_MAX losses.
//  4 Push DEPTH ALU entries with no pops possible (LSU saturating, STARVE_MAX large) ->
//    alu_ready=0 after DEPTH; further alu_valid not accepted; all entries later written in order.
//  5 ALU push rd=0 data=0xFFFF -> handshake completes, we never asserted for it.
//  6 Three ALU entries queued, flush -> next cycle ALU FIFO empty, no writes from them;
//    with WB_SCOREBOARD_EN busy_vec bits for those rds clear.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and the writeback entry payload for the writeback arbiter.
package wb_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the ALU/LSU producers, the writeback arbiter and the regfile port.
// busy_vec exists only when WB_SCOREBOARD_EN is defined.
interface wb_arbiter_if
  import wb_pkg::*;
;
  logic              flush;
  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              we;
  logic [REG_AW-1:0] waddr;
  logic [XLEN-1:0]   wdata;
`ifdef WB_SCOREBOARD_EN
  logic [NREGS-1:0]  busy_vec;
`endif

  modport master (
    output flush, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, we, waddr, wdata
`ifdef WB_SCOREBOARD_EN
    , input busy_vec
`endif
  );

  modport slave (
    input  flush, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, we, waddr, wdata
`ifdef WB_SCOREBOARD_EN
    , output busy_vec
`endif
  );
endinterface

// File: rtl/wb_fifo.sv
// Per-source result FIFO with extra-MSB pointers; entries/entry_valid are exported
// only under WB_SCOREBOARD_EN for the busy-register scoreboard.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
`ifdef WB_SCOREBOARD_EN
  , output wb_entry_t        entries [DEPTH]
  , output logic [DEPTH-1:0] entry_valid
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is not reset; pointers alone define which slots hold live data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

`ifdef WB_SCOREBOARD_EN
  logic [PW-1:0] count;
  logic [AW-1:0] offset;

  assign count   = wr_ptr - rd_ptr;
  assign entries = mem;

  // Slot i is live when its distance from the read pointer is below the fill count.
  always_comb begin
    entry_valid = '0;
    offset      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset         = AW'(i) - rd_ptr[AW-1:0];
      entry_valid[i] = ({1'b0, offset} < count);
    end
  end
`endif
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU and LSU result FIFOs merged onto one regfile write port,
// LSU priority with an ALU starvation guard. Optional busy_vec via WB_SCOREBOARD_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic      alu_full, alu_empty, lsu_full, lsu_empty;
  logic      alu_push, lsu_push;
  logic      alu_win, lsu_win;
  wb_entry_t alu_head, lsu_head;
  wb_entry_t alu_in, lsu_in;
  logic [SW-1:0] starve_q, starve_d;

  assign bus.alu_ready = !alu_full;
  assign bus.lsu_ready = !lsu_full;

  // Writes to x0 complete the handshake but never occupy a slot.
  assign alu_push = bus.alu_valid && !alu_full && (bus.alu_rd != '0) && !bus.flush;
  assign lsu_push = bus.lsu_valid && !lsu_full && (bus.lsu_rd != '0);
  assign alu_in   = '{rd: bus.alu_rd, data: bus.alu_data};
  assign lsu_in   = '{rd: bus.lsu_rd, data: bus.lsu_data};

`ifdef WB_SCOREBOARD_EN
  wb_entry_t        alu_entries [DEPTH];
  wb_entry_t        lsu_entries [DEPTH];
  logic [DEPTH-1:0] alu_ev, lsu_ev;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .push       (alu_push),
    .push_entry (alu_in),
    .pop        (alu_win),
    .full       (alu_full),
    .empty      (alu_empty),
    .head       (alu_head)
`ifdef WB_SCOREBOARD_EN
    , .entries     (alu_entries)
    , .entry_valid (alu_ev)
`endif
  );

  wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (1'b0),
    .push       (lsu_push),
    .push_entry (lsu_in),
    .pop        (lsu_win),
    .full       (lsu_full),
    .empty      (lsu_empty),
    .head       (lsu_head)
`ifdef WB_SCOREBOARD_EN
    , .entries     (lsu_entries)
    , .entry_valid (lsu_ev)
`endif
  );

  // LSU wins contention unless the ALU head has already lost STARVE_MAX times in a row.
  always_comb begin
    alu_win   = !alu_empty && (lsu_empty || (starve_q == STARVE_LIM));
    lsu_win   = !lsu_empty && !alu_win;
    bus.we    = alu_win || lsu_win;
    bus.waddr = '0;
    bus.wdata = '0;
    if (alu_win) begin
      bus.waddr = alu_head.rd;
      bus.wdata = alu_head.data;
    end else if (lsu_win) begin
      bus.waddr = lsu_head.rd;
      bus.wdata = lsu_head.data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (bus.flush || alu_empty || alu_win) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

`ifdef WB_SCOREBOARD_EN
  always_comb begin
    bus.busy_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alu_ev[i]) bus.busy_vec[alu_entries[i].rd] = 1'b1;
      if (lsu_ev[i]) bus.busy_vec[lsu_entries[i].rd] = 1'b1;
    end
    bus.busy_vec[0] = 1'b0;
  end
`endif
endmodule
